prbs_rx_checker: RTL and testbench
==================================

Name: prbs_rx_checker

Overview:
- Receive-side PRBS checker in the digital core; the counterpart of the PRBS transmitter used in loopback.
- Consumes one word of N_LANES sliced ADC sign bits per clk_adc cycle, after lane reordering into time order.
- Self-seeds a local LFSR from the received data, verifies alignment, then declares lock.
- While locked, counts bit errors, checked bits and loss-of-lock events for JTAG readout.

Parameters:
N_LANES, 16, bits per word; bit 0 is the earliest in time.
PRBS_ORDER, 7, LFSR order; legal values are 7 and 15. Elaboration error if PRBS_ORDER > N_LANES.
CNT_WIDTH, 40, width of the err_cnt and bit_cnt counters.
LOCK_WORDS, 4, consecutive error-free words in VERIFY needed to declare lock.
UNLOCK_ERR, 8, per-word error count at or above which a word is "bad".
UNLOCK_WORDS, 2, consecutive bad words in CHECK that force a relock.

Ports:
clk_adc  in  1  core clock.
rstb  in  1  asynchronous active-low reset.
en  in  1  checker enable; low forces IDLE.
invert  in  1  XOR all rx_bits with 1 before use (channel polarity swap).
clear  in  1  synchronous clear of all counters.
rx_valid  in  1  rx_bits is valid this cycle.
rx_bits  in  N_LANES  received word.
locked  out  1  high only in CHECK.
state  out  2  0=IDLE, 1=ALIGN, 2=VERIFY, 3=CHECK.
word_err  out  $clog2(N_LANES+1)  error popcount of the last compared word.
err_cnt  out  CNT_WIDTH  accumulated bit errors; saturating.
bit_cnt  out  CNT_WIDTH  accumulated checked bits; saturating.
loss_cnt  out  8  count of CHECK->ALIGN transitions; saturating.

Behaviour:
- Reset: all outputs 0, state IDLE, LFSR state 0.
- Sequence recurrence: b[n] = b[n-PRBS_ORDER] ^ b[n-PRBS_ORDER+1].
- Prediction: combinational, from the stored PRBS_ORDER-bit history, unrolled N_LANES bits per word. d = (rx_bits ^ {N_LANES{invert}}) ^ predicted.
- Only cycles with rx_valid=1 advance the FSM, update word_err, or update counters. Non-valid cycles hold everything.
- All outputs are registered; a valid word at edge t is reflected in the outputs after edge t.
- IDLE: entered when en=0, from any state, immediately on the next edge. locked=0; counters hold. en=1 -> ALIGN.
- ALIGN: on a valid word, load history = its last PRBS_ORDER bits (post-invert) and go to VERIFY with clean-word count = 0.
- VERIFY: on each valid word, compare against the prediction.
  - Any error: go to ALIGN; the next valid word reseeds.
  - No error: clean-word count increments. On reaching LOCK_WORDS, go to CHECK with locked=1.
  - History advances with the received bits.
- CHECK: on each valid word, history advances with the predicted bits, not the received bits, so errors do not propagate.
  - err_cnt += popcount(d); bit_cnt += N_LANES; both saturate at all-ones.
  - A word with popcount >= UNLOCK_ERR increments the bad-word run; any other word resets the run to 0.
  - When the run reaches UNLOCK_WORDS: go to ALIGN, locked=0, loss_cnt+1. That word's errors are still counted.
- Lock timing with default parameters and clean data: seed word W0, clean words W1..W4. locked rises on the edge of W4; W5 is the first counted word.
- clear: zeroes err_cnt, bit_cnt and loss_cnt. If clear and a counted word land on the same edge, clear wins and the result is 0. The FSM is unaffected.
- Reset asserted mid-operation: returns to reset values asynchronously. After release, relock starts from IDLE/ALIGN.
- invert toggled while in CHECK: errors will exceed threshold and the block relocks; no special handling.

Decomposition:
- Shared package prbs_pack:
  - state enum type;
  - PRBS tap constants for orders 7 and 15;
  - function prbs_next_word(history, order, n) returning the predicted word and next history.
- The TX PRBS model reuses the same function.
- Sub-module popcount: parameterised combinational adder tree, width N_LANES.
- The FSM and counters stay in prbs_rx_checker.

Test Plan:
- Clean PRBS7 stream, 16 lanes, rx_valid every cycle, en=1 after reset. Required: locked on the 5th valid word edge. After 100 further words: err_cnt=0, bit_cnt=1600.
- Single bit flip injected in one counted word. Required: word_err=1 for that word, err_cnt=1, locked stays 1, no further errors (no propagation).
- Two consecutive words inverted in full (16 errors each). Required: state ALIGN after the second word, loss_cnt=1, err_cnt=32. Relock 5 words later.
- Stream inverted with invert=0. Required: never reaches CHECK. With invert=1: locks normally, err_cnt=0.
- rx_valid toggling 1/0 each cycle. Required: lock after 5 valid words (10 cycles); bit_cnt advances 16 per valid word only.
- clear asserted on the same edge as a counted error word. Required: err_cnt=0.
- rstb pulsed low while in CHECK. Required: all outputs 0 immediately; relock after release.
- PRBS15 build: lock and zero errors on a clean stream.

Source files
------------

// File: rtl/prbs_pack.sv
// rtl/prbs_pack.sv - shared PRBS types, tap constants and word-wide sequence predictor
// Used by the RX checker and by the TX PRBS model.
package prbs_pack;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ALIGN  = 2'd1,
    ST_VERIFY = 2'd2,
    ST_CHECK  = 2'd3
  } prbs_state_t;

  localparam int MAX_ORDER = 15;
  localparam int MAX_LANES = 64;

  // History masks with bit 0 holding the most recent bit; the set bits are the
  // taps of x^7+x^6+1 and x^15+x^14+1.
  localparam logic [MAX_ORDER-1:0] PRBS7_TAPS  = 15'h0060;
  localparam logic [MAX_ORDER-1:0] PRBS15_TAPS = 15'h6000;

  typedef struct packed {
    logic [MAX_LANES-1:0] word;
    logic [MAX_ORDER-1:0] hist;
  } prbs_step_t;

  // Unrolls the recurrence n bits forward; word bit 0 is the earliest bit.
  function automatic prbs_step_t prbs_next_word(input logic [MAX_ORDER-1:0] history,
                                                input int order,
                                                input int n);
    logic [MAX_ORDER-1:0] taps;
    logic [MAX_ORDER-1:0] keep;
    logic [MAX_ORDER-1:0] h;
    logic                 b;
    prbs_step_t           r;
    taps = (order == 15) ? PRBS15_TAPS : PRBS7_TAPS;
    keep = (order == 15) ? 15'h7fff : 15'h007f;
    h    = history & keep;
    b    = 1'b0;
    r    = '0;
    for (int i = 0; i < MAX_LANES; i++) begin
      if (i < n) begin
        b         = ^(h & taps);
        r.word[i] = b;
        h         = ((h << 1) | {{(MAX_ORDER-1){1'b0}}, b}) & keep;
      end
    end
    r.hist = h;
    return r;
  endfunction

endpackage

// File: rtl/prbs_rx_checker_popcount.sv
// rtl/prbs_rx_checker_popcount.sv - combinational adder-tree popcount
// Leaves are padded to a power of two; node k sums nodes 2k and 2k+1.
module prbs_rx_checker_popcount #(
  parameter int W  = 16,
  parameter int OW = $clog2(W + 1)
) (
  input  logic [W-1:0]  data,
  output logic [OW-1:0] count
);

  localparam int P = (W <= 1) ? 1 : (1 << $clog2(W));

  logic [OW-1:0] node [1:2*P-1];

  always_comb begin
    node = '{default: '0};
    for (int i = 0; i < W; i++) begin
      node[P+i] = OW'(data[i]);
    end
    for (int k = P - 1; k >= 1; k--) begin
      node[k] = node[2*k] + node[2*k+1];
    end
    count = node[1];
  end

endmodule

// File: rtl/prbs_rx_checker.sv
// rtl/prbs_rx_checker.sv - self-seeding PRBS receive checker with lock FSM and error counters
// ALIGN seeds from the data, VERIFY confirms alignment, CHECK counts errors.
module prbs_rx_checker
  import prbs_pack::*;
#(
  parameter int N_LANES      = 16,
  parameter int PRBS_ORDER   = 7,
  parameter int CNT_WIDTH    = 40,
  parameter int LOCK_WORDS   = 4,
  parameter int UNLOCK_ERR   = 8,
  parameter int UNLOCK_WORDS = 2
) (
  input  logic                         clk_adc,
  input  logic                         rstb,
  input  logic                         en,
  input  logic                         invert,
  input  logic                         clear,
  input  logic                         rx_valid,
  input  logic [N_LANES-1:0]           rx_bits,
  output logic                         locked,
  output logic [1:0]                   state,
  output logic [$clog2(N_LANES+1)-1:0] word_err,
  output logic [CNT_WIDTH-1:0]         err_cnt,
  output logic [CNT_WIDTH-1:0]         bit_cnt,
  output logic [7:0]                   loss_cnt
);

  localparam int EW = $clog2(N_LANES + 1);
  localparam int LW = $clog2(LOCK_WORDS + 1);
  localparam int UW = $clog2(UNLOCK_WORDS + 1);

  if (PRBS_ORDER != 7 && PRBS_ORDER != 15) begin : g_bad_order
    $error("prbs_rx_checker: PRBS_ORDER must be 7 or 15");
  end
  if (PRBS_ORDER > N_LANES) begin : g_order_too_wide
    $error("prbs_rx_checker: PRBS_ORDER must not exceed N_LANES");
  end
  if (N_LANES > MAX_LANES) begin : g_too_many_lanes
    $error("prbs_rx_checker: N_LANES exceeds the predictor width");
  end

  prbs_state_t           st_q;
  logic [PRBS_ORDER-1:0] hist_q;
  logic [LW-1:0]         clean_q;
  logic [UW-1:0]         bad_q;

  logic [N_LANES-1:0]    rx_word;
  logic [N_LANES-1:0]    pred;
  logic [N_LANES-1:0]    diff;
  logic [PRBS_ORDER-1:0] pred_hist;
  logic [PRBS_ORDER-1:0] rx_hist;
  logic [MAX_ORDER-1:0]  hist_ext;
  prbs_step_t            step;
  logic                  unused_step;
  logic [EW-1:0]         pop;

  logic [CNT_WIDTH:0]    err_sum;
  logic [CNT_WIDTH:0]    bit_sum;
  logic [CNT_WIDTH-1:0]  err_next;
  logic [CNT_WIDTH-1:0]  bit_next;
  logic [7:0]            loss_next;
  logic                  bad_word;
  logic                  clean_hit;
  logic                  run_hit;
  logic                  count_word;

  assign rx_word  = rx_bits ^ {N_LANES{invert}};
  assign hist_ext = MAX_ORDER'(hist_q);

  always_comb begin
    step      = prbs_next_word(hist_ext, PRBS_ORDER, N_LANES);
    pred      = step.word[N_LANES-1:0];
    pred_hist = step.hist[PRBS_ORDER-1:0];
  end

  assign unused_step = ^{step.word, step.hist};
  assign diff        = rx_word ^ pred;

  // The newest received bit (MSB of the word) becomes history bit 0.
  always_comb begin
    rx_hist = '0;
    for (int k = 0; k < PRBS_ORDER; k++) begin
      rx_hist[k] = rx_word[N_LANES-1-k];
    end
  end

  prbs_rx_checker_popcount #(
    .W  (N_LANES),
    .OW (EW)
  ) u_popcount (
    .data  (diff),
    .count (pop)
  );

  assign err_sum   = {1'b0, err_cnt} + {{(CNT_WIDTH+1-EW){1'b0}}, pop};
  assign bit_sum   = {1'b0, bit_cnt} + (CNT_WIDTH+1)'(N_LANES);
  assign err_next  = err_sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : err_sum[CNT_WIDTH-1:0];
  assign bit_next  = bit_sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : bit_sum[CNT_WIDTH-1:0];
  assign loss_next = (loss_cnt == 8'hff) ? 8'hff : loss_cnt + 8'd1;

  assign bad_word   = int'(pop) >= UNLOCK_ERR;
  assign clean_hit  = (int'(clean_q) + 1) >= LOCK_WORDS;
  assign run_hit    = (int'(bad_q) + 1) >= UNLOCK_WORDS;
  assign count_word = en && rx_valid && (st_q == ST_CHECK);

  assign state = st_q;

  always_ff @(posedge clk_adc or negedge rstb) begin
    if (!rstb) begin
      st_q     <= ST_IDLE;
      hist_q   <= '0;
      clean_q  <= '0;
      bad_q    <= '0;
      locked   <= 1'b0;
      word_err <= '0;
      err_cnt  <= '0;
      bit_cnt  <= '0;
      loss_cnt <= '0;
    end else begin
      if (!en) begin
        st_q   <= ST_IDLE;
        locked <= 1'b0;
      end else begin
        case (st_q)
          ST_IDLE: st_q <= ST_ALIGN;
          ST_ALIGN: begin
            if (rx_valid) begin
              hist_q  <= rx_hist;
              clean_q <= '0;
              st_q    <= ST_VERIFY;
            end
          end
          ST_VERIFY: begin
            if (rx_valid) begin
              word_err <= pop;
              hist_q   <= rx_hist;
              if (pop != '0) begin
                st_q <= ST_ALIGN;
              end else if (clean_hit) begin
                st_q   <= ST_CHECK;
                locked <= 1'b1;
                bad_q  <= '0;
              end else begin
                clean_q <= clean_q + LW'(1);
              end
            end
          end
          ST_CHECK: begin
            if (rx_valid) begin
              word_err <= pop;
              // Advance on the prediction so a corrupted word cannot poison the history.
              hist_q   <= pred_hist;
              if (bad_word) begin
                if (run_hit) begin
                  st_q     <= ST_ALIGN;
                  locked   <= 1'b0;
                  bad_q    <= '0;
                  loss_cnt <= loss_next;
                end else begin
                  bad_q <= bad_q + UW'(1);
                end
              end else begin
                bad_q <= '0;
              end
            end
          end
          default: st_q <= ST_IDLE;
        endcase
      end

      if (count_word) begin
        err_cnt <= err_next;
        bit_cnt <= bit_next;
      end
      // Clear overrides any count landing on the same edge.
      if (clear) begin
        err_cnt  <= '0;
        bit_cnt  <= '0;
        loss_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_prbs_rx_checker.sv
// tb/tb_prbs_rx_checker.sv - scoreboard bench for prbs_rx_checker (PRBS7 main DUT, PRBS15 build)
module tb_prbs_rx_checker;

  localparam int N     = 16;
  localparam int CW    = 40;
  localparam int ORD   = 7;
  localparam int LOCKW = 4;
  localparam int UERR  = 8;
  localparam int UWDS  = 2;
  localparam longint CMAX = (64'sd1 <<< CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstb, en, invert, clear, rx_valid;
  logic [N-1:0]  rx_bits;
  logic          locked;
  logic [1:0]    state;
  logic [4:0]    word_err;
  logic [CW-1:0] err_cnt, bit_cnt;
  logic [7:0]    loss_cnt;

  logic          en15, inv15, clr15, valid15;
  logic [N-1:0]  bits15;
  logic          locked15;
  logic [1:0]    state15;
  logic [4:0]    werr15;
  logic [CW-1:0] err15, bit15;
  logic [7:0]    loss15;

  prbs_rx_checker #(.N_LANES(N), .PRBS_ORDER(7), .CNT_WIDTH(CW)) dut (
    .clk_adc(clk), .rstb(rstb), .en(en), .invert(invert), .clear(clear),
    .rx_valid(rx_valid), .rx_bits(rx_bits), .locked(locked), .state(state),
    .word_err(word_err), .err_cnt(err_cnt), .bit_cnt(bit_cnt), .loss_cnt(loss_cnt));

  prbs_rx_checker #(.N_LANES(N), .PRBS_ORDER(15), .CNT_WIDTH(CW)) dut15 (
    .clk_adc(clk), .rstb(rstb), .en(en15), .invert(inv15), .clear(clr15),
    .rx_valid(valid15), .rx_bits(bits15), .locked(locked15), .state(state15),
    .word_err(werr15), .err_cnt(err15), .bit_cnt(bit15), .loss_cnt(loss15));

  typedef struct {
    int     st;
    int     lk;
    int     werr;
    longint err;
    longint bits;
    int     loss;
  } exp_t;

  exp_t   sb[$];
  int     n_vec  = 0;
  int     n_miss = 0;

  bit     tx7[$];
  bit     tx15[$];

  int     m_st, m_clean, m_bad, m_werr, m_loss;
  longint m_err, m_bitc;
  bit     m_hist[$];

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [N-1:0] gen_word(input int order);
    logic [N-1:0] w;
    bit nb;
    for (int i = 0; i < N; i++) begin
      if (order == 15) begin
        nb = tx15[0] ^ tx15[1];
        tx15.push_back(nb);
        void'(tx15.pop_front());
      end else begin
        nb = tx7[0] ^ tx7[1];
        tx7.push_back(nb);
        void'(tx7.pop_front());
      end
      w[i] = nb;
    end
    return w;
  endfunction

  function automatic void model_reset();
    m_st = 0; m_clean = 0; m_bad = 0; m_werr = 0; m_loss = 0;
    m_err = 0; m_bitc = 0;
    m_hist.delete();
  endfunction

  function automatic void model_seed(input logic [N-1:0] w);
    m_hist.delete();
    for (int i = N - ORD; i < N; i++) m_hist.push_back(w[i]);
  endfunction

  function automatic logic [N-1:0] model_predict();
    logic [N-1:0] p;
    for (int i = 0; i < N; i++) begin
      p[i] = m_hist[0] ^ m_hist[1];
      m_hist.push_back(p[i]);
      void'(m_hist.pop_front());
    end
    return p;
  endfunction

  function automatic void model_step(bit e, bit inv, bit clr, bit v, logic [N-1:0] bits);
    logic [N-1:0] w, p;
    int errs;
    w = bits ^ {N{inv}};
    if (!e) m_st = 0;
    else begin
      case (m_st)
        0: m_st = 1;
        1: if (v) begin model_seed(w); m_clean = 0; m_st = 2; end
        2: if (v) begin
          p = model_predict();
          errs = $countones(w ^ p);
          m_werr = errs;
          model_seed(w);
          if (errs != 0) m_st = 1;
          else begin
            m_clean++;
            if (m_clean == LOCKW) begin m_st = 3; m_bad = 0; end
          end
        end
        default: if (v) begin
          p = model_predict();
          errs = $countones(w ^ p);
          m_werr = errs;
          m_err  = (m_err + errs > CMAX) ? CMAX : m_err + errs;
          m_bitc = (m_bitc + N > CMAX) ? CMAX : m_bitc + N;
          if (errs >= UERR) m_bad++; else m_bad = 0;
          if (m_bad == UWDS) begin
            m_st = 1; m_bad = 0;
            m_loss = (m_loss == 255) ? 255 : m_loss + 1;
          end
        end
      endcase
    end
    if (clr) begin m_err = 0; m_bitc = 0; m_loss = 0; end
  endfunction

  task automatic drive(bit e, bit inv, bit clr, bit v, logic [N-1:0] bits);
    exp_t x;
    en = e; invert = inv; clear = clr; rx_valid = v; rx_bits = bits;
    model_step(e, inv, clr, v, bits);
    x.st = m_st; x.lk = (m_st == 3); x.werr = m_werr;
    x.err = m_err; x.bits = m_bitc; x.loss = m_loss;
    @(posedge clk);
    sb.push_back(x);
    #1;
  endtask

  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        x = sb.pop_front();
        check("state", state, x.st);
        check("locked", locked, x.lk);
        check("word_err", word_err, x.werr);
        check("err_cnt", err_cnt, x.err);
        check("bit_cnt", bit_cnt, x.bits);
        check("loss_cnt", loss_cnt, x.loss);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: bench did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] w;
    int seen, burst;
    bit v, e, c;

    rstb = 1'b0; en = 0; invert = 0; clear = 0; rx_valid = 0; rx_bits = '0;
    en15 = 0; inv15 = 0; clr15 = 0; valid15 = 0; bits15 = '0;
    model_reset();
    w = N'($urandom_range(127, 1));
    for (int i = 0; i < 7; i++) tx7.push_back(w[i]);
    w = N'($urandom_range(32767, 1));
    for (int i = 0; i < 15; i++) tx15.push_back(w[i]);

    repeat (2) @(posedge clk);
    #1;
    check("rst_state", state, 0);
    check("rst_locked", locked, 0);
    check("rst_err", err_cnt, 0);
    check("rst_bits", bit_cnt, 0);
    check("rst_loss", loss_cnt, 0);
    check("rst_werr", word_err, 0);
    rstb = 1'b1;

    // Clean lock: seed W0, W1..W4 clean, locked on W4.
    drive(1, 0, 0, 0, '0);
    for (int k = 0; k < 5; k++) begin
      drive(1, 0, 0, 1, gen_word(7));
      check("lock_edge", locked, (k == 4));
    end
    for (int k = 0; k < 100; k++) drive(1, 0, 0, 1, gen_word(7));
    check("clean_err", err_cnt, 0);
    check("clean_bits", bit_cnt, 1600);

    // Single flip: one error, no propagation.
    w = gen_word(7);
    w[$urandom_range(N-1, 0)] ^= 1'b1;
    drive(1, 0, 0, 1, w);
    check("flip_werr", word_err, 1);
    check("flip_err", err_cnt, 1);
    check("flip_locked", locked, 1);
    for (int k = 0; k < 10; k++) drive(1, 0, 0, 1, gen_word(7));
    check("flip_noprop", err_cnt, 1);

    // Two fully inverted words force a relock.
    drive(1, 0, 1, 1, gen_word(7));
    drive(1, 0, 0, 1, gen_word(7) ^ {N{1'b1}});
    drive(1, 0, 0, 1, gen_word(7) ^ {N{1'b1}});
    check("unlock_state", state, 1);
    check("unlock_loss", loss_cnt, 1);
    check("unlock_err", err_cnt, 32);
    for (int k = 0; k < 5; k++) begin
      drive(1, 0, 0, 1, gen_word(7));
      check("relock_edge", locked, (k == 4));
    end

    // Complemented stream: no lock without invert, lock with it.
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      drive(1, 0, 0, 1, ~gen_word(7));
      if (k >= 1 && locked === 1'b1) seen++;
    end
    check("inv0_never_locked", seen, 0);
    drive(1, 1, 1, 1, ~gen_word(7));
    for (int k = 0; k < 30; k++) drive(1, 1, 0, 1, ~gen_word(7));
    check("inv1_locked", locked, 1);
    check("inv1_err", err_cnt, 0);

    // rx_valid toggling: lock after 5 valid words, 16 bits per valid word.
    drive(0, 0, 1, 0, '0);
    drive(1, 0, 0, 0, '0);
    for (int c2 = 0; c2 < 20; c2++) begin
      if (c2 % 2 == 0) drive(1, 0, 0, 1, gen_word(7));
      else drive(1, 0, 0, 0, N'($urandom));
      if (c2 < 10) check("toggle_lock", locked, (c2 >= 8));
    end
    check("toggle_bits", bit_cnt, 80);

    // Clear wins over a counted error word.
    w = gen_word(7);
    w[$urandom_range(N-1, 0)] ^= 1'b1;
    drive(1, 0, 1, 1, w);
    check("clear_wins", err_cnt, 0);

    // Randomized traffic against the model.
    burst = 0;
    for (int k = 0; k < 400; k++) begin
      v = ($urandom_range(3, 0) != 0);
      e = ($urandom_range(99, 0) != 0);
      c = ($urandom_range(49, 0) == 0);
      if (v) begin
        w = gen_word(7);
        if (burst > 0) begin
          w = w ^ {N{1'b1}};
          burst--;
        end else if ($urandom_range(99, 0) < 3) begin
          burst = $urandom_range(3, 1);
        end else if ($urandom_range(99, 0) < 6) begin
          w[$urandom_range(N-1, 0)] ^= 1'b1;
        end
      end else begin
        w = N'($urandom);
      end
      drive(e, 0, c, v, w);
    end

    // Asynchronous reset while in CHECK.
    drive(0, 0, 0, 0, '0);
    drive(1, 0, 0, 0, '0);
    for (int k = 0; k < 6; k++) drive(1, 0, 0, 1, gen_word(7));
    check("pre_rst_locked", locked, 1);
    @(negedge clk);
    #1;
    rstb = 1'b0;
    #1;
    check("arst_state", state, 0);
    check("arst_locked", locked, 0);
    check("arst_err", err_cnt, 0);
    check("arst_bits", bit_cnt, 0);
    check("arst_loss", loss_cnt, 0);
    check("arst_werr", word_err, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rstb = 1'b1;
    drive(1, 0, 0, 0, '0);
    for (int k = 0; k < 5; k++) begin
      drive(1, 0, 0, 1, gen_word(7));
      check("post_rst_lock", locked, (k == 4));
    end
    drive(0, 0, 0, 0, '0);
    @(negedge clk);
    #1;
    check("sb_drain", sb.size(), 0);

    // PRBS15 build on a clean stream.
    en15 = 1; valid15 = 0; bits15 = '0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 30; k++) begin
      valid15 = 1;
      bits15  = gen_word(15);
      @(posedge clk);
      #1;
      check("p15_lock", locked15, (k >= 4));
    end
    check("p15_state", state15, 3);
    check("p15_err", err15, 0);
    check("p15_bits", bit15, 25 * 16);
    check("p15_loss", loss15, 0);
    check("p15_werr", werr15, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
